// File: rtl/pc_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_unit_if : fetch-control bus between front-end control and pc_unit     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic             stall_i;
  logic             exc_i;
  logic             redirect_i;
  logic [WIDTH-1:0] redirect_pc_i;
  logic             call_i;
  logic [WIDTH-1:0] call_target_i;
  logic             ret_i;
  logic [WIDTH-1:0] pc_o;
  logic             valid_o;
  logic             ras_empty_o;
  logic             ras_full_o;
  logic             err_o;
  logic             misalign_o;

  modport master (
    output start_i, stall_i, exc_i, redirect_i, redirect_pc_i,
           call_i, call_target_i, ret_i,
    input  pc_o, valid_o, ras_empty_o, ras_full_o, err_o, misalign_o
  );

  modport slave (
    input  start_i, stall_i, exc_i, redirect_i, redirect_pc_i,
           call_i, call_target_i, ret_i,
    output pc_o, valid_o, ras_empty_o, ras_full_o, err_o, misalign_o
  );
endinterface
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_unit : program counter with redirect, exception and return stack     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h40),
  parameter int unsigned      INC          = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  pc_unit_if.slave bus
);
  localparam int unsigned        c_PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned        c_CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0]   c_INC      = WIDTH'(INC);
  localparam logic [WIDTH-1:0]   c_LOW_MASK = WIDTH'(INC - 1);
  localparam logic [c_PTR_W-1:0] c_LAST     = c_PTR_W'(RAS_DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0]   r_ras [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_pc;
  logic               r_valid;
  logic               r_err;
  logic               r_mis;

  logic [WIDTH-1:0]   w_pc_inc;
  logic [c_PTR_W-1:0] w_ptr_next;
  logic [c_PTR_W-1:0] w_ptr_prev;
  logic               w_empty;
  logic               w_full;
  logic               w_hold;

  // r_ptr is the next write slot; the top of stack sits one slot behind it.
  assign w_pc_inc   = r_pc + c_INC;
  assign w_ptr_next = (r_ptr == c_LAST) ? '0 : r_ptr + 1'b1;
  assign w_ptr_prev = (r_ptr == '0) ? c_LAST : r_ptr - 1'b1;
  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == c_FULL);
  assign w_hold     = !bus.start_i || bus.stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc    <= RESET_VECTOR;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_valid <= bus.start_i || bus.exc_i || bus.redirect_i;
      r_mis   <= 1'b0;
      if (bus.exc_i) begin
        r_pc  <= EXC_VECTOR;
        r_cnt <= '0;
      end else if (bus.redirect_i) begin
        r_pc  <= bus.redirect_pc_i & ~c_LOW_MASK;
        r_mis <= |(bus.redirect_pc_i & c_LOW_MASK);
      end else if (w_hold) begin
        r_pc <= r_pc;
      end else if (bus.ret_i) begin
        if (w_empty) begin
          r_pc  <= w_pc_inc;
          r_err <= 1'b1;
        end else begin
          r_pc  <= r_ras[w_ptr_prev];
          r_ptr <= w_ptr_prev;
          r_cnt <= r_cnt - 1'b1;
        end
      end else if (bus.call_i) begin
        // When full, r_ptr already addresses the oldest entry, so the push overwrites it.
        r_ras[r_ptr] <= w_pc_inc;
        r_ptr        <= w_ptr_next;
        r_pc         <= bus.call_target_i & ~c_LOW_MASK;
        r_mis        <= |(bus.call_target_i & c_LOW_MASK);
        if (w_full) begin
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_pc <= w_pc_inc;
      end
    end
  end

  assign bus.pc_o        = r_pc;
  assign bus.valid_o     = r_valid;
  assign bus.ras_empty_o = w_empty;
  assign bus.ras_full_o  = w_full;
  assign bus.err_o       = r_err;
  assign bus.misalign_o  = r_mis;
endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_unit : directed scenarios plus random run against a queue model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pc_unit;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_i;
  int   n_chk = 0;
  int   n_err = 0;

  pc_unit_if #(.WIDTH(32)) bus ();
  pc_unit_if #(.WIDTH(8))  bus8 ();

  pc_unit #(.WIDTH(32), .RAS_DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  pc_unit #(.WIDTH(8), .RAS_DEPTH(DEPTH)) dut8 (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus8.slave)
  );

  always #5 clk = ~clk;

  // Reference model: architectural PC plus a bounded LIFO of return addresses.
  logic [31:0] m_pc;
  logic        m_valid, m_err, m_mis;
  logic [31:0] m_stack[$];

  task automatic step(input logic rst, input logic start, input logic stall, input logic exc,
                      input logic redir, input logic [31:0] rpc, input logic call,
                      input logic [31:0] ct, input logic ret);
    logic [31:0] ret_addr;
    rst_i             = rst;
    bus.start_i       = start;
    bus.stall_i       = stall;
    bus.exc_i         = exc;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    bus.call_i        = call;
    bus.call_target_i = ct;
    bus.ret_i         = ret;
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_err = 1'b0; m_mis = 1'b0;
      m_stack.delete();
    end else begin
      m_valid = start | exc | redir;
      m_mis   = 1'b0;
      if (exc) begin
        m_pc = 32'h40;
        m_stack.delete();
      end else if (redir) begin
        m_pc  = (rpc / 4) * 4;
        m_mis = (rpc % 4) != 0;
      end else if (!start || stall) begin
        m_pc = m_pc;
      end else if (ret) begin
        if (m_stack.size() == 0) begin
          m_pc  = m_pc + 4;
          m_err = 1'b1;
        end else begin
          ret_addr = m_stack.pop_back();
          m_pc     = ret_addr;
        end
      end else if (call) begin
        m_stack.push_back(m_pc + 4);
        if (m_stack.size() > DEPTH) begin
          void'(m_stack.pop_front());
          m_err = 1'b1;
        end
        m_pc  = (ct / 4) * 4;
        m_mis = (ct % 4) != 0;
      end else begin
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h123, 1'b1, 32'h456, 1'b1);
    n_chk++;
    if ({bus.pc_o, bus.valid_o, bus.ras_empty_o, bus.ras_full_o, bus.err_o, bus.misalign_o}
        !== {32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state actual pc=%h v=%b e=%b f=%b err=%b mis=%b required pc=0 v=0 e=1 f=0 err=0 mis=0",
               bus.pc_o, bus.valid_o, bus.ras_empty_o, bus.ras_full_o, bus.err_o, bus.misalign_o);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc[4]  = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic        exp_v[4]   = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      n_chk++;
      if (bus.pc_o !== exp_pc[i] || bus.valid_o !== exp_v[i]) begin
        n_err++;
        $display("FAIL seq_step%0d actual pc=%h valid=%b required pc=%h valid=%b",
                 i, bus.pc_o, bus.valid_o, exp_pc[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
      n_chk++;
      if (bus.pc_o !== 32'h8 || bus.misalign_o !== 1'b0 || bus.ras_empty_o !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold%0d actual pc=%h mis=%b empty=%b required pc=8 mis=0 empty=1",
                 i, bus.pc_o, bus.misalign_o, bus.ras_empty_o);
      end
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h103, 1'b0, 32'h0, 1'b0);
    n_chk++;
    if (bus.pc_o !== 32'h100 || bus.misalign_o !== 1'b1) begin
      n_err++;
      $display("FAIL redirect_stall actual pc=%h mis=%b required pc=100 mis=1", bus.pc_o, bus.misalign_o);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_chk++;
    if (bus.pc_o !== 32'h100 || bus.misalign_o !== 1'b0 || bus.valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_pulse actual pc=%h mis=%b valid=%b required pc=100 mis=0 valid=0",
               bus.pc_o, bus.misalign_o, bus.valid_o);
    end
  endtask

  task automatic fill_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
      n_chk++;
      if (bus.pc_o !== 32'h200 || bus.ras_full_o !== (i >= 4) || bus.err_o !== (i == 5)) begin
        n_err++;
        $display("FAIL call%0d actual pc=%h full=%b err=%b required pc=200 full=%b err=%b",
                 i, bus.pc_o, bus.ras_full_o, bus.err_o, i >= 4, i == 5);
      end
    end
  endtask

  task automatic test_ras_overflow();
    fill_overflow();
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      n_chk++;
      if (bus.pc_o !== ((i == 5) ? 32'h208 : 32'h204) || bus.ras_empty_o !== (i >= 4)
          || bus.err_o !== 1'b1) begin
        n_err++;
        $display("FAIL ret%0d actual pc=%h empty=%b err=%b required pc=%h empty=%b err=1",
                 i, bus.pc_o, bus.ras_empty_o, bus.err_o, (i == 5) ? 32'h208 : 32'h204, i >= 4);
      end
    end
  endtask

  task automatic test_reset_midop();
    fill_overflow();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0);
    n_chk++;
    if ({bus.pc_o, bus.valid_o, bus.ras_empty_o, bus.ras_full_o, bus.err_o, bus.misalign_o}
        !== {32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_midop actual pc=%h v=%b e=%b f=%b err=%b mis=%b required pc=0 v=0 e=1 f=0 err=0 mis=0",
               bus.pc_o, bus.valid_o, bus.ras_empty_o, bus.ras_full_o, bus.err_o, bus.misalign_o);
    end
  endtask

  task automatic test_exc_clear();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_chk++;
    if (bus.pc_o !== 32'h40 || bus.ras_empty_o !== 1'b1 || bus.valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL exc_clear actual pc=%h empty=%b valid=%b required pc=40 empty=1 valid=1",
               bus.pc_o, bus.ras_empty_o, bus.valid_o);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_chk++;
    if (bus.pc_o !== 32'h44 || bus.err_o !== 1'b1) begin
      n_err++;
      $display("FAIL ret_underflow actual pc=%h err=%b required pc=44 err=1", bus.pc_o, bus.err_o);
    end
  endtask

  task automatic test_call_ret_same();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4C, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h333, 1'b1);
    n_chk++;
    if (bus.pc_o !== 32'h50 || bus.ras_empty_o !== 1'b1 || bus.misalign_o !== 1'b0
        || bus.err_o !== 1'b0) begin
      n_err++;
      $display("FAIL call_ret_same actual pc=%h empty=%b mis=%b err=%b required pc=50 empty=1 mis=0 err=0",
               bus.pc_o, bus.ras_empty_o, bus.misalign_o, bus.err_o);
    end
  endtask

  task automatic test_wrap8();
    bus8.start_i = 1'b0; bus8.stall_i = 1'b0; bus8.exc_i = 1'b0; bus8.call_i = 1'b0;
    bus8.ret_i = 1'b0; bus8.call_target_i = 8'h0;
    bus8.redirect_i = 1'b0; bus8.redirect_pc_i = 8'h0;
    do_reset();
    bus8.redirect_i = 1'b1; bus8.redirect_pc_i = 8'hFC;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    bus8.redirect_i = 1'b0; bus8.start_i = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_chk++;
    if (bus8.pc_o !== 8'h00 || bus8.err_o !== 1'b0 || bus8.valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL wrap8 actual pc=%h err=%b valid=%b required pc=00 err=0 valid=1",
               bus8.pc_o, bus8.err_o, bus8.valid_o);
    end
    bus8.start_i = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] rpc, ct;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rpc = $urandom();
      ct  = ($urandom_range(0, 1) == 1) ? ($urandom() & 32'hFFFF_FFFC) : $urandom();
      if (i == 5) rpc = 32'hFFFF_FFF8;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0, rpc,
           $urandom_range(0, 2) == 0, ct, $urandom_range(0, 3) == 0);
      n_chk++;
      if ({bus.pc_o, bus.valid_o, bus.ras_empty_o, bus.ras_full_o, bus.err_o, bus.misalign_o}
          !== {m_pc, m_valid, m_stack.size() == 0, m_stack.size() == DEPTH, m_err, m_mis}) begin
        n_err++;
        $display("FAIL random%0d actual pc=%h v=%b e=%b f=%b err=%b mis=%b required pc=%h v=%b e=%b f=%b err=%b mis=%b",
                 i, bus.pc_o, bus.valid_o, bus.ras_empty_o, bus.ras_full_o, bus.err_o, bus.misalign_o,
                 m_pc, m_valid, m_stack.size() == 0, m_stack.size() == DEPTH, m_err, m_mis);
      end
    end
  endtask

  initial begin
    bus8.start_i = 1'b0; bus8.stall_i = 1'b0; bus8.exc_i = 1'b0; bus8.redirect_i = 1'b0;
    bus8.redirect_pc_i = 8'h0; bus8.call_i = 1'b0; bus8.call_target_i = 8'h0; bus8.ret_i = 1'b0;
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_ras_overflow();
    test_reset_midop();
    test_exc_clear();
    test_call_ret_same();
    test_wrap8();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
